// File: rtl/pc_flag_unit.sv
// pc_flag_unit: execute-stage back end of the SIMPLE core (flags, PC, branches, halt).
// Optional BR_COUNT_EN adds a saturating taken-branch counter on br_count.
module pc_flag_unit #(
  parameter int PC_W   = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] alu_x,
  input  logic [3:0]        alu_code,
  input  logic              flag_we,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        flags,
  output logic              taken,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  br_count
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [3:0]      flags_nx;

  logic is_b;
  logic is_c;
  logic is_hlt;
  logic cond_ok;
  logic br_hit;
  logic act;
  logic s_f;
  logic z_f;
  logic v_f;

  assign is_b   = instr[15:11] == 5'b10100;
  assign is_c   = instr[15:11] == 5'b10111;
  assign is_hlt = (instr[15:14] == 2'b11) &&
                  (instr[7:4] == 4'b1111);

  // Conditions look only at committed flags.
  assign s_f = flags[3];
  assign z_f = flags[2];
  assign v_f = flags[0];

  always_comb begin
    cond_ok = 1'b0;
    case (instr[10:8])
      3'b000:  cond_ok = z_f;
      3'b001:  cond_ok = s_f ^ v_f;
      3'b010:  cond_ok = z_f | (s_f ^ v_f);
      3'b011:  cond_ok = !z_f;
      default: cond_ok = 1'b0;
    endcase
  end

  assign br_hit = is_b | (is_c & cond_ok);
  assign act    = ex_valid & !stall & (state == RUN);
  assign taken  = act & br_hit;
  assign flush  = state == FLUSH;
  assign halted = state == HALT;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    flags_nx = flags;
    unique case (state)
      RUN: begin
        if (!stall) begin
          if (!ex_valid) begin
            pc_nx = pc + PC_W'(1);
          end else begin
            if (flag_we) flags_nx = alu_code;
            unique case (1'b1)
              br_hit: begin
                pc_nx    = alu_x[PC_W-1:0];
                state_nx = FLUSH;
              end
              is_hlt: state_nx = HALT;
              default: pc_nx = pc + PC_W'(1);
            endcase
          end
        end
      end
      FLUSH: begin
        if (!stall) state_nx = RUN;
      end
      HALT: state_nx = HALT;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= '0;
      flags <= 4'b0000;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      flags <= flags_nx;
    end
  end

`ifdef BR_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (taken && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign br_count = cnt_q;
`else
  assign br_count = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{alu_x[DATA_W-1:PC_W], instr[3:0]};

endmodule

// File: tb/tb_pc_flag_unit.sv
// tb_pc_flag_unit: directed vectors with a scoreboard queue and a negedge monitor.
// Expected br_count follows BR_COUNT_EN (saturating 4-bit) or stays 0.
module tb_pc_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        ex_valid;
  logic [15:0] instr;
  logic [15:0] alu_x;
  logic [3:0]  alu_code;
  logic        flag_we;
  logic [11:0] pc;
  logic [3:0]  flags;
  logic        taken;
  logic        flush;
  logic        halted;
  logic [3:0]  br_count;

  pc_flag_unit #(
    .PC_W  (12),
    .DATA_W(16),
    .CNT_W (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall   (stall),
    .ex_valid(ex_valid),
    .instr   (instr),
    .alu_x   (alu_x),
    .alu_code(alu_code),
    .flag_we (flag_we),
    .pc      (pc),
    .flags   (flags),
    .taken   (taken),
    .flush   (flush),
    .halted  (halted),
    .br_count(br_count)
  );

  typedef struct {
    bit          chk;
    logic [11:0] pc;
    logic [3:0]  flags;
    logic        taken;
    logic        flush;
    logic        halted;
    logic [3:0]  cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_taken  = 0;
  bit   drv_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] cnt_exp(input int n);
`ifdef BR_COUNT_EN
    cnt_exp = (n > 15) ? 4'hF : n[3:0];
`else
    cnt_exp = 4'h0;
`endif
  endfunction

  task automatic step(
    input logic        rn,
    input logic        st,
    input logic        ev,
    input logic [15:0] in,
    input logic [15:0] ax,
    input logic [3:0]  ac,
    input logic        fw,
    input bit          chk,
    input logic [11:0] epc,
    input logic [3:0]  efl,
    input logic        et,
    input logic        ef,
    input logic        eh,
    input string       nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rn;
    stall    = st;
    ex_valid = ev;
    instr    = in;
    alu_x    = ax;
    alu_code = ac;
    flag_we  = fw;
    e.chk    = chk;
    e.pc     = epc;
    e.flags  = efl;
    e.taken  = et;
    e.flush  = ef;
    e.halted = eh;
    e.cnt    = cnt_exp(n_taken);
    e.name   = nm;
    sb.push_back(e);
    if (!rn) n_taken = 0;
    else if (et) n_taken = n_taken + 1;
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          checks++;
          if (pc !== e.pc || flags !== e.flags || taken !== e.taken ||
              flush !== e.flush || halted !== e.halted ||
              br_count !== e.cnt) begin
            failures++;
            $display("FAIL %s: got pc=%h fl=%h tk=%b fu=%b hl=%b cnt=%h want pc=%h fl=%h tk=%b fu=%b hl=%b cnt=%h",
                     e.name, pc, flags, taken, flush, halted, br_count,
                     e.pc, e.flags, e.taken, e.flush, e.halted, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; ex_valid = 1'b0;
    instr = '0; alu_x = '0; alu_code = '0; flag_we = 1'b0;

    step(0,0,0,16'h0,16'h0,4'h0,0, 0, 12'h000,4'h0,0,0,0,"init");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h000,4'h0,0,0,0,"reset_state");
    step(1,0,1,16'hA000,16'h0123,4'hF,1, 1, 12'h001,4'h0,1,0,0,"b_taken");
    step(0,0,0,16'h0,16'h0,4'h0,0, 1, 12'h123,4'hF,0,1,0,"pre_reset");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h000,4'h0,0,0,0,"mid_reset");
    step(1,0,1,16'h0000,16'h0,4'h4,1, 1, 12'h001,4'h0,0,0,0,"cmp");
    step(1,0,1,16'hB800,16'h0040,4'h0,0, 1, 12'h002,4'h4,1,0,0,"be_taken");
    step(1,0,1,16'hB800,16'h0999,4'hF,1, 1, 12'h040,4'h4,0,1,0,"be_squash");
    step(1,0,1,16'h0000,16'h0,4'h8,1, 1, 12'h040,4'h4,0,0,0,"post_flush");
    step(1,0,1,16'hB900,16'h0080,4'h0,0, 1, 12'h041,4'h8,1,0,0,"blt_taken");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h080,4'h8,0,1,0,"blt_flush");
    step(1,0,1,16'h0000,16'h0,4'h4,1, 1, 12'h080,4'h8,0,0,0,"set_z");
    step(1,0,1,16'hBB00,16'h0300,4'h0,0, 1, 12'h081,4'h4,0,0,0,"bne_not");
    step(1,0,1,16'hBA00,16'h00FF,4'h0,1, 1, 12'h082,4'h4,1,0,0,"ble_old_flags");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h0FF,4'h0,0,1,0,"ble_flush");
    step(1,0,1,16'hBC00,16'h0777,4'h0,0, 1, 12'h0FF,4'h0,0,0,0,"never");
    step(1,0,1,16'hA000,16'h0FFF,4'h0,0, 1, 12'h100,4'h0,1,0,0,"b_fff");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'hFFF,4'h0,0,1,0,"fff_flush");
    step(1,0,1,16'h0000,16'h0,4'h0,0, 1, 12'hFFF,4'h0,0,0,0,"add_wrap");
    step(1,0,1,16'h0000,16'h0,4'h4,1, 1, 12'h000,4'h0,0,0,0,"cmp_z");
    step(1,1,1,16'hB800,16'h0555,4'h0,1, 1, 12'h001,4'h4,0,0,0,"be_stall");
    step(1,0,1,16'hB800,16'h0055,4'h0,0, 1, 12'h001,4'h4,1,0,0,"be_unstall");
    step(1,1,0,16'h0,16'h0,4'h0,0, 1, 12'h055,4'h4,0,1,0,"flush_stall");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h055,4'h4,0,1,0,"flush_held");
    step(1,0,1,16'hA000,16'h0010,4'h0,0, 1, 12'h055,4'h4,1,0,0,"b_010");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h010,4'h4,0,1,0,"b010_flush");
    step(1,0,1,16'hC0F0,16'h0,4'h0,0, 1, 12'h010,4'h4,0,0,0,"hlt");
    for (int i = 0; i < 20; i++) begin
      step(1,i[0],1,16'hA000,16'h0333,4'hF,1, 1, 12'h010,4'h4,0,0,1,"halt_hold");
    end
    step(0,0,0,16'h0,16'h0,4'h0,0, 1, 12'h010,4'h4,0,0,1,"halt_pre_reset");
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h000,4'h0,0,0,0,"halt_reset");
    for (int i = 0; i < 17; i++) begin
      logic [11:0] p;
      logic [15:0] t;
      p = (i == 0) ? 12'h001 : 12'(12'h200 + i - 1);
      t = 16'(16'h0200 + i);
      step(1,0,1,16'hA000,t,4'h0,0, 1, p,4'h0,1,0,0,"cnt_b");
      step(1,0,0,16'h0,16'h0,4'h0,0, 1, t[11:0],4'h0,0,1,0,"cnt_flush");
    end
    step(1,0,0,16'h0,16'h0,4'h0,0, 1, 12'h210,4'h0,0,0,0,"cnt_final");

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
